// File: rtl/snake_pkg.sv
// Shared definitions for the game's memory clients: client identifiers and
// the default starvation limit used by the SRAM arbiter.
package snake_pkg;

    typedef enum logic {
        CLIENT_DISPLAY = 1'b0,
        CLIENT_SCORE   = 1'b1
    } client_e;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_arbiter.sv
// Two-client arbiter in front of a single-port SRAM with 1-cycle read latency.
// Client 0 (display) has priority; client 1 (score) wins after STARVE_LIMIT lost cycles.
module sram_arbiter
    import snake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  c0_req,
    input  logic                  c0_we,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [DATA_WIDTH-1:0] c0_wdata,
    output logic                  c0_gnt,
    output logic                  c0_rvalid,
    output logic [DATA_WIDTH-1:0] c0_rdata,

    input  logic                  c1_req,
    input  logic                  c1_we,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [DATA_WIDTH-1:0] c1_wdata,
    output logic                  c1_gnt,
    output logic                  c1_rvalid,
    output logic [DATA_WIDTH-1:0] c1_rdata,

    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    client_e    owner_q, owner_d;
    logic       c0_rvalid_q, c0_rvalid_d;
    logic       c1_rvalid_q, c1_rvalid_d;
    logic       c0_win, c1_win;

    // Grants are suppressed while reset is held so nothing reaches the SRAM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        c0_win = 1'b0;
        c1_win = 1'b0;
        if (!reset) begin
            if (c1_req && (starve_cnt_q == LIMIT || !c0_req)) begin
                c1_win = 1'b1;
            end else if (c0_req) begin
                c0_win = 1'b1;
            end
        end
    end

    always_comb begin
        sram_en      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        owner_d      = owner_q;
        c0_rvalid_d  = 1'b0;
        c1_rvalid_d  = 1'b0;
        starve_cnt_d = '0;

        if (c0_win) begin
            sram_en     = 1'b1;
            sram_we     = c0_we;
            sram_addr   = c0_addr;
            sram_wdata  = c0_wdata;
            owner_d     = CLIENT_DISPLAY;
            c0_rvalid_d = !c0_we;
        end else if (c1_win) begin
            sram_en     = 1'b1;
            sram_we     = c1_we;
            sram_addr   = c1_addr;
            sram_wdata  = c1_wdata;
            owner_d     = CLIENT_SCORE;
            c1_rvalid_d = !c1_we;
        end

        // Saturating count of cycles client 1 asked and lost.
        if (c1_req && !c1_win) begin
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            owner_q      <= CLIENT_DISPLAY;
            c0_rvalid_q  <= 1'b0;
            c1_rvalid_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            c0_rvalid_q  <= c0_rvalid_d;
            c1_rvalid_q  <= c1_rvalid_d;
        end
    end

    assign c0_gnt    = c0_win;
    assign c1_gnt    = c1_win;
    assign c0_rvalid = c0_rvalid_q;
    assign c1_rvalid = c1_rvalid_q;

    // Read data is steered only to the owner of a pending read; writes never echo back.
    assign c0_rdata = (c0_rvalid_q && owner_q == CLIENT_DISPLAY) ? sram_rdata : '0;
    assign c1_rdata = (c1_rvalid_q && owner_q == CLIENT_SCORE)   ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_sram_arbiter;
    import snake_pkg::*;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          c0_req = 1'b0, c0_we = 1'b0;
    logic [AW-1:0] c0_addr = '0;
    logic [DW-1:0] c0_wdata = '0;
    logic          c0_gnt, c0_rvalid;
    logic [DW-1:0] c0_rdata;
    logic          c1_req = 1'b0, c1_we = 1'b0;
    logic [AW-1:0] c1_addr = '0;
    logic [DW-1:0] c1_wdata = '0;
    logic          c1_gnt, c1_rvalid;
    logic [DW-1:0] c1_rdata;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        client_e       id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Registered SRAM; a write echoes its data onto the read port to expose leaks.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                sram_rdata     <= sram_wdata;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rvalid();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("c0_rvalid", c0_rvalid, e.id == CLIENT_DISPLAY);
            check("c1_rvalid", c1_rvalid, e.id == CLIENT_SCORE);
            check("c0_rdata", c0_rdata, (e.id == CLIENT_DISPLAY) ? e.data : 8'h00);
            check("c1_rdata", c1_rdata, (e.id == CLIENT_SCORE) ? e.data : 8'h00);
        end else begin
            check("c0_rvalid_idle", c0_rvalid, 1'b0);
            check("c1_rvalid_idle", c1_rvalid, 1'b0);
            check("c0_rdata_idle", c0_rdata, 8'h00);
            check("c1_rdata_idle", c1_rdata, 8'h00);
        end
    endtask

    // exp_g: 0 = no grant, 1 = client 0, 2 = client 1; exp_data is the read result.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input int exp_g, input logic [DW-1:0] exp_data);
        c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
        #3;
        check("c0_gnt", c0_gnt, exp_g == 1);
        check("c1_gnt", c1_gnt, exp_g == 2);
        check("sram_en", sram_en, exp_g != 0);
        if (exp_g == 1) begin
            check("sram_addr_c0", sram_addr, a0);
            check("sram_we_c0", sram_we, w0);
            check("sram_wdata_c0", sram_wdata, d0);
            if (!w0) sb.push_back('{CLIENT_DISPLAY, exp_data});
        end else if (exp_g == 2) begin
            check("sram_addr_c1", sram_addr, a1);
            check("sram_we_c1", sram_we, w1);
            check("sram_wdata_c1", sram_wdata, d1);
            if (!w1) sb.push_back('{CLIENT_SCORE, exp_data});
        end else begin
            check("sram_we_idle", sram_we, 1'b0);
            check("sram_addr_idle", sram_addr, 16'h0000);
            check("sram_wdata_idle", sram_wdata, 8'h00);
        end
        @(posedge clk);
        #1;
        check_rvalid();
    endtask

    initial begin
        mem[16'h0010] = 8'h5A;
        mem[16'h0001] = 8'h11;
        mem[16'h0002] = 8'h22;

        // Reset state, and a read presented while reset is held.
        #2;
        check("rst_c0_rvalid", c0_rvalid, 1'b0);
        check("rst_c1_rvalid", c1_rvalid, 1'b0);
        check("rst_c0_rdata", c0_rdata, 8'h00);
        c0_req = 1'b1; c0_addr = 16'h0010;
        c1_req = 1'b1; c1_addr = 16'h0002;
        #1;
        check("rst_c0_gnt", c0_gnt, 1'b0);
        check("rst_c1_gnt", c1_gnt, 1'b0);
        check("rst_sram_en", sram_en, 1'b0);
        check("rst_sram_we", sram_we, 1'b0);
        @(posedge clk);
        #1;
        check("rst_read_no_rvalid", c0_rvalid, 1'b0);
        reset = 1'b0;

        // Single display read.
        step(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h5A);

        // Continuous contention: four display grants then one score grant.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 16'h0001, 8'h00, 1, 0, 16'h0002, 8'h00,
                 (i % 5 == 4) ? 2 : 1, (i % 5 == 4) ? 8'h22 : 8'h11);
        end

        // Back-to-back alternating reads.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) step(1, 0, 16'h0001, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h11);
            else            step(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0002, 8'h00, 2, 8'h22);
        end

        // Score write, then read back the same address.
        step(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0100, 8'hA3, 2, 8'h00);
        step(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0100, 8'h00, 2, 8'hA3);
        step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00);

        // Score request withdrawn after losing three cycles: counter must restart.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0001, 8'h00, 1, 0, 16'h0002, 8'h00, 1, 8'h11);
        end
        step(1, 0, 16'h0001, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h11);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 16'h0001, 8'h00, 1, 0, 16'h0002, 8'h00, (i == 4) ? 2 : 1, (i == 4) ? 8'h22 : 8'h11);
        end

        // Reset asserted in the cycle after a display read grant.
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 16'h0010;
        c1_req = 1'b0;
        #3;
        check("pre_rst_c0_gnt", c0_gnt, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_c0_rvalid", c0_rvalid, 1'b1);
        check("pre_rst_c0_rdata", c0_rdata, 8'h5A);
        reset = 1'b1;
        #1;
        check("midrst_c0_rvalid", c0_rvalid, 1'b0);
        check("midrst_c0_rdata", c0_rdata, 8'h00);
        check("midrst_c0_gnt", c0_gnt, 1'b0);
        check("midrst_sram_en", sram_en, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_hold_gnt", c0_gnt, 1'b0);
        check("midrst_hold_rvalid", c0_rvalid, 1'b0);
        reset = 1'b0;

        // First grant right after reset release.
        step(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h5A);
        step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
